// File: rtl/hw_accel_pixel_packer.sv
// hw_accel_pixel_packer
// Packs an 8-bit pixel stream into little-endian OUT_WIDTH-bit words.
// Each word carries a last-of-frame tag. Words are buffered in a show-ahead
// FIFO so the consumer can stall. The pixel source has no ready signal, so a
// full FIFO drops the completed word and sets a sticky overflow flag.
// Optional feature macro: HW_ACCEL_PACKER_FRAME_CNT_EN adds frame_done and
// frame_count outputs.
module hw_accel_pixel_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    input  logic                  pixel_in_sof,
    output logic [OUT_WIDTH-1:0]  word_out,
    output logic                  word_out_valid,
    output logic                  word_out_last,
    input  logic                  word_out_ready,
    output logic                  overflow,
    input  logic                  overflow_clr
`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
    ,
    output logic                  frame_done,
    output logic [15:0]           frame_count
`endif
);

    localparam int PPW   = OUT_WIDTH / DATA_WIDTH;
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int SW    = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(PPW - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(TOTAL - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    logic [SW-1:0]        slot_q, slot_d, eff_slot;
    logic [PW-1:0]        pix_q, pix_d, eff_pix;
    logic [OUT_WIDTH-1:0] part_q, part_d, cur_word;
    logic                 complete, word_last;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 fifo_empty, fifo_full, wr_en, rd_en, drop;
    logic [OUT_WIDTH:0]   mem [FIFO_DEPTH];
    logic [OUT_WIDTH:0]   head;

    // SOF forces the pixel into slot 0 of frame position 0
    always_comb begin
        eff_slot  = pixel_in_sof ? '0 : slot_q;
        eff_pix   = pixel_in_sof ? '0 : pix_q;
        complete  = pixel_in_valid && (eff_slot == SLOT_LAST);
        word_last = (eff_pix == PIX_LAST);
    end

    // Per-lane merge: the incoming pixel takes its slot; slot 0 starts a clean word
    generate
        for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
            assign cur_word[gi*DATA_WIDTH +: DATA_WIDTH] =
                (eff_slot == SW'(gi)) ? pixel_in :
                (eff_slot == '0)      ? '0       :
                                        part_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Slot, frame position and partial word advance on every accepted pixel
    always_comb begin
        slot_d = slot_q;
        pix_d  = pix_q;
        part_d = part_q;
        if (pixel_in_valid) begin
            slot_d = complete ? '0 : eff_slot + SW'(1);
            pix_d  = word_last ? '0 : eff_pix + PW'(1);
            part_d = complete ? '0 : cur_word;
        end
    end

    // FIFO control: a read frees a slot for a same-cycle write when full
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FIFO_FULL);
        rd_en      = !fifo_empty && word_out_ready;
        wr_en      = complete && (!fifo_full || rd_en);
        drop       = complete && fifo_full && !rd_en;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            pix_q    <= '0;
            part_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            pix_q    <= pix_d;
            part_q   <= part_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Word storage; contents are only visible while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {word_last, cur_word};
        end
    end

    // Show-ahead head; forced to zero when empty so reset clears outputs at once
    always_comb begin
        head           = mem[rd_ptr_q];
        word_out_valid = !fifo_empty;
        word_out       = fifo_empty ? '0 : head[OUT_WIDTH-1:0];
        word_out_last  = !fifo_empty && head[OUT_WIDTH];
        overflow       = ovf_q;
    end

`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
    logic        frame_done_q;
    logic [15:0] frame_count_q;

    // Pulse after a last-tagged word is taken; count follows the pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q  <= rd_en && word_out_last;
            frame_count_q <= frame_done_q ? frame_count_q + 16'd1 : frame_count_q;
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_hw_accel_pixel_packer.sv
// Testbench for hw_accel_pixel_packer (4x2 frame, 32-bit words, 2-deep FIFO).
// Expected words are queued when pixels are driven and compared on handshake.
module tb_hw_accel_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pixel_in;
    logic        pixel_in_valid;
    logic        pixel_in_sof;
    logic [31:0] word_out;
    logic        word_out_valid;
    logic        word_out_last;
    logic        word_out_ready;
    logic        overflow;
    logic        overflow_clr;
`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
    logic        frame_done;
    logic [15:0] frame_count;
`endif

    hw_accel_pixel_packer #(
        .DATA_WIDTH (8),
        .OUT_WIDTH  (32),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_in       (pixel_in),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in_sof   (pixel_in_sof),
        .word_out       (word_out),
        .word_out_valid (word_out_valid),
        .word_out_last  (word_out_last),
        .word_out_ready (word_out_ready),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr)
`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
        ,
        .frame_done     (frame_done),
        .frame_count    (frame_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [32:0] sb_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_word;
    logic        hold_last;
    logic        exp_fd = 1'b0;
    int          fd_model = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic push_exp(input logic [31:0] w, input logic l);
        sb_q.push_back({l, w});
    endtask

    task automatic drive(input logic [7:0] p, input logic s);
        pixel_in       = p;
        pixel_in_sof   = s;
        pixel_in_valid = 1'b1;
    endtask

    task automatic send_pix(input logic [7:0] p, input logic s);
        drive(p, s);
        @(posedge clk); #1;
    endtask

    task automatic send_group(input logic [7:0] base, input int n, input logic sof_first);
        for (int i = 0; i < n; i++) send_pix(8'(int'(base) + i), sof_first && (i == 0));
    endtask

    task automatic idle(input int n);
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b0;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop, hold stability, frame_done timing
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
            exp_fd       = 1'b0;
            fd_model     = 0;
        end else begin
`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
            if (frame_done || exp_fd) chk("frame_done", 64'(frame_done), 64'(exp_fd));
            if (exp_fd) fd_model++;
`endif
            exp_fd = 1'b0;
            if (hold_pending && word_out_valid) begin
                chk("hold_word", 64'(word_out), 64'(hold_word));
                chk("hold_last", 64'(word_out_last), 64'(hold_last));
            end
            if (word_out_valid && word_out_ready) begin
                $display("pop word=0x%08h last=%0d", word_out, word_out_last);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    logic [32:0] e;
                    e = sb_q.pop_front();
                    chk("word", 64'(word_out), 64'(e[31:0]));
                    chk("last", 64'(word_out_last), 64'(e[32]));
                end
                exp_fd = word_out_last;
            end
            hold_pending = word_out_valid && !word_out_ready;
            hold_word    = word_out;
            hold_last    = word_out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b0;
        word_out_ready = 1'b0;
        overflow_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(word_out_valid), 64'd0);
        chk("rst_last",  64'(word_out_last),  64'd0);
        chk("rst_word",  64'(word_out),       64'd0);
        chk("rst_ovf",   64'(overflow),       64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tiny frame with ready high, including first-word latency
        word_out_ready = 1'b1;
        push_exp(32'h04030201, 1'b0);
        push_exp(32'h08070605, 1'b1);
        send_group(8'h01, 3, 1'b1);
        drive(8'h04, 1'b0);
        @(negedge clk);
        chk("lat_pre", 64'(word_out_valid), 64'd0);
        @(posedge clk); #1;
        drive(8'h05, 1'b0);
        @(negedge clk);
        chk("lat_post", 64'(word_out_valid), 64'd1);
        @(posedge clk); #1;
        send_group(8'h06, 3, 1'b0);
        drain();

        // Backpressure: full FIFO held while ready is low
        word_out_ready = 1'b0;
        push_exp(32'h14131211, 1'b0);
        push_exp(32'h18171615, 1'b1);
        send_group(8'h11, 8, 1'b1);
        idle(6);
        chk("bp_valid", 64'(word_out_valid), 64'd1);
        chk("bp_ovf",   64'(overflow),       64'd0);
        word_out_ready = 1'b1;
        drain();

        // Overflow: third word dropped, alignment kept afterwards
        word_out_ready = 1'b0;
        push_exp(32'h44434241, 1'b0);
        push_exp(32'h48474645, 1'b1);
        send_group(8'h41, 8, 1'b1);
        send_group(8'h51, 4, 1'b1);
        idle(2);
        chk("ovf_set", 64'(overflow), 64'd1);
        word_out_ready = 1'b1;
        drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        push_exp(32'h58575655, 1'b1);
        send_group(8'h55, 4, 1'b0);
        push_exp(32'h64636261, 1'b0);
        push_exp(32'h68676665, 1'b1);
        send_group(8'h61, 8, 1'b0);
        drain();
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Drop and clear in the same cycle: set wins
        word_out_ready = 1'b0;
        push_exp(32'h74737271, 1'b0);
        push_exp(32'h78777675, 1'b1);
        send_group(8'h71, 8, 1'b1);
        send_group(8'h79, 3, 1'b0);
        overflow_clr = 1'b1;
        send_pix(8'h7C, 1'b0);
        overflow_clr = 1'b0;
        idle(1);
        chk("ovf_set_wins", 64'(overflow), 64'd1);
        word_out_ready = 1'b1;
        drain();
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        chk("ovf_clr2", 64'(overflow), 64'd0);

        // Mid-frame SOF discards the partial word
        send_group(8'hA1, 2, 1'b0);
        push_exp(32'h14131211, 1'b0);
        push_exp(32'h18171615, 1'b1);
        send_group(8'h11, 8, 1'b1);
        drain();

        // Asynchronous reset with pending words, overflow and a partial word
        word_out_ready = 1'b0;
        send_group(8'hC1, 12, 1'b1);
        send_group(8'hB1, 2, 1'b0);
        pixel_in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(word_out_valid), 64'd1);
        chk("pre_rst_ovf",   64'(overflow),       64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(word_out_valid), 64'd0);
        chk("arst_last",  64'(word_out_last),  64'd0);
        chk("arst_word",  64'(word_out),       64'd0);
        chk("arst_ovf",   64'(overflow),       64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        word_out_ready = 1'b1;
        push_exp(32'hD4D3D2D1, 1'b0);
        send_group(8'hD1, 4, 1'b0);
        drain();
        push_exp(32'hD8D7D6D5, 1'b1);
        send_group(8'hD5, 4, 1'b0);
        drain();

`ifdef HW_ACCEL_PACKER_FRAME_CNT_EN
        // Three back-to-back frames
        begin
            logic [15:0] fc_start;
            idle(3);
            fc_start = frame_count;
            for (int f = 0; f < 3; f++) begin
                push_exp({8'(16*f + 4), 8'(16*f + 3), 8'(16*f + 2), 8'(16*f + 1)}, 1'b0);
                push_exp({8'(16*f + 8), 8'(16*f + 7), 8'(16*f + 6), 8'(16*f + 5)}, 1'b1);
            end
            for (int f = 0; f < 3; f++) send_group(8'(16*f + 1), 8, 1'b1);
            drain();
            idle(3);
            chk("fc_delta", 64'(frame_count - fc_start), 64'd3);
            chk("fc_model", 64'(frame_count), 64'(fd_model));
        end
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hw_accel_pixel_packer.md
Name: hw_accel_pixel_packer

Overview:
Downstream stage of the hardware accelerator output mux. Packs the 8-bit processed pixel stream into OUT_WIDTH-bit words and tags the last word of each frame. Buffers words in a small show-ahead FIFO so a DMA/AXI-stream writer can apply backpressure. The upstream accelerator has no ready signal, so FIFO overrun is detected and flagged rather than back-propagated.

Parameters:
DATA_WIDTH, 8, pixel width in bits
OUT_WIDTH, 32, packed word width; must be a multiple of DATA_WIDTH; PPW = OUT_WIDTH/DATA_WIDTH
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame; IMG_WIDTH*IMG_HEIGHT must be a multiple of PPW
FIFO_DEPTH, 16, word FIFO depth; power of 2, at least 2

Ports:
clk  input  1  single system clock
rst_n  input  1  asynchronous active-low reset
pixel_in  input  DATA_WIDTH  processed pixel
pixel_in_valid  input  1  pixel_in is valid this cycle; no ready, always accepted
pixel_in_sof  input  1  qualified by pixel_in_valid; this pixel is the first of a frame
word_out  output  OUT_WIDTH  packed word, FIFO head
word_out_valid  output  1  FIFO not empty
word_out_last  output  1  word_out is the final word of a frame
word_out_ready  input  1  consumer accepts the word when valid and ready are both high
overflow  output  1  sticky; set when a completed word is dropped
overflow_clr  input  1  one-cycle pulse that clears overflow

Behaviour:
- Reset: all counters 0, partial word 0, FIFO empty. word_out_valid=0, word_out_last=0, overflow=0, word_out=0.
- Packing is little-endian. The first pixel of each group lands in bits [DATA_WIDTH-1:0]; pixel k of the group lands in bits [k*DATA_WIDTH +: DATA_WIDTH].
- slot_cnt runs 0..PPW-1. pix_cnt runs 0..IMG_WIDTH*IMG_HEIGHT-1 and advances on each accepted pixel.
- Word completion: occurs on the pixel with slot_cnt==PPW-1. The word, with its last flag, is written to the FIFO on that same clock edge. last = (pix_cnt == IMG_WIDTH*IMG_HEIGHT-1).
- Latency: word_out_valid rises 1 cycle after the completing pixel when the FIFO was empty.
- End of frame: pix_cnt and slot_cnt wrap to 0 after the last pixel of the frame.
- SOF resync: pixel_in_valid && pixel_in_sof forces this pixel into slot 0 with pix_cnt=0.
  - Any partial word in progress is discarded and never written.
  - If SOF arrives exactly at a natural frame boundary, nothing changes.
- FIFO: show-ahead. Read occurs when word_out_valid && word_out_ready.
- Simultaneous write and read when full: both proceed; no overflow.
- Simultaneous write and read when empty: the written word appears next cycle and the read is ignored, because valid was 0.
- Write while full with no read: the word is dropped and overflow is set on the next edge. pix_cnt and slot_cnt still advance, so frame alignment is preserved.
- word_out and word_out_last must hold stable while valid && !ready.
- overflow_clr clears overflow. If a drop occurs in the same cycle, set wins.
- pixel_in_valid=0 cycles are bubbles; state holds.

Optional Feature:
Macro: HW_ACCEL_PACKER_FRAME_CNT_EN.
- When defined, two output ports are added:
  - frame_done (1 bit): single-cycle pulse in the cycle after a last-tagged word is read by the consumer.
  - frame_count (16 bits): increments on each frame_done, wraps at 65535 to 0, reset to 0.
- When undefined, neither port nor the counter logic exists. All other behaviour is identical.

Test Plan:
- Single tiny frame. IMG_WIDTH=4, IMG_HEIGHT=2, OUT_WIDTH=32. Stimulus: pixels 0x01..0x08 with ready held high, SOF on the first pixel. Expected: words 0x04030201 (last=0) then 0x08070605 (last=1). First valid appears 1 cycle after pixel 4.
- Backpressure. Same frame, ready low for 6 cycles, FIFO_DEPTH=2. Expected: both words held stable and delivered in order after ready rises, overflow=0.
- Overflow. FIFO_DEPTH=2, ready held low for 3 full words. Expected: the third word is dropped and overflow=1. After ready rises, the next frame's first word is still correctly aligned with last flags on time. An overflow_clr pulse returns overflow to 0.
- Mid-frame SOF. Stimulus: pixels 0xA1,0xA2, then SOF with pixels 0x11..0x14. Expected: 0xA1/0xA2 are never emitted; the next word is 0x14131211.
- Reset mid-word. Stimulus: assert rst_n=0 after 2 pixels. Expected: all outputs are 0 immediately (asynchronous). After release, 4 pixels produce exactly one word containing only the new pixels.
- With HW_ACCEL_PACKER_FRAME_CNT_EN defined. Stimulus: 3 back-to-back frames. Expected: 3 frame_done pulses, each 1 cycle after the last word's handshake, and frame_count=3.
